// File: rtl/vdp_vram_arb.sv
// -----------------------------------------------------------------------------
// vdp_vram_arb
//
// Shares one single-port synchronous VRAM (one-cycle read latency) between the
// graphics fetch FSM and the CPU register interface. VDP fetches always own the
// port in the cycle of their tick. A CPU read or write is held in a one-deep
// buffer and issued in the first cycle without a tick.
//
// Handshake: the CPU side is a pulse-request / busy interface. A request
// (cpu_wr_req or cpu_rd_req) is accepted only in a cycle where cpu_busy is
// low. Requests made while cpu_busy is high are dropped. A read completes with
// a one-cycle cpu_rd_valid pulse, and cpu_rd_data holds its value until the
// next read. The VDP side has no back-pressure. A tick in cycle T yields data
// on vram_dout in T+1, and that value is held until the cycle after the next
// tick.
//
// Ports
//   pxclk, reset        pixel clock; synchronous active-high reset
//   vdp_dma_addr/_tick  fetch address and 1-cycle fetch strobe
//   vram_dout           fetch data to graphics FSM
//   cpu_addr/wr_data    CPU access address and write byte
//   cpu_wr_req/rd_req   CPU request pulses (write wins if both)
//   cpu_busy            request buffer occupied
//   cpu_rd_data/_valid  CPU read result and 1-cycle completion pulse
//   ram_addr/din/we     VRAM port
//   ram_dout            VRAM read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module vdp_vram_arb #(
   parameter int VRAM_SIZE       = 8*1024,
   parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
   input  logic                       pxclk,
   input  logic                       reset,
   input  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
   input  logic                       vdp_dma_rd_tick,
   output logic [7:0]                 vram_dout,
   input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
   input  logic [7:0]                 cpu_wr_data,
   input  logic                       cpu_wr_req,
   input  logic                       cpu_rd_req,
   output logic                       cpu_busy,
   output logic [7:0]                 cpu_rd_data,
   output logic                       cpu_rd_valid,
   output logic [VRAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [7:0]                 ram_din,
   output logic                       ram_we,
   input  logic [7:0]                 ram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_RDWAIT = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic                       op_wr_q, op_wr_d;
   logic [VRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                 data_q, data_d;
   logic                       vdp_rd_d1_q, vdp_rd_d1_d;
   logic [7:0]                 hold_q, hold_d;
   logic [7:0]                 cpu_rd_data_q, cpu_rd_data_d;
   logic                       cpu_rd_valid_q, cpu_rd_valid_d;
   logic [7:0]                 stall_cnt_q, stall_cnt_d;

   // Next-state and datapath updates.
   always_comb begin
      state_d        = state_q;
      op_wr_d        = op_wr_q;
      addr_d         = addr_q;
      data_d         = data_q;
      vdp_rd_d1_d    = vdp_dma_rd_tick;
      hold_d         = hold_q;
      cpu_rd_data_d  = cpu_rd_data_q;
      cpu_rd_valid_d = 1'b0;
      stall_cnt_d    = stall_cnt_q;

      // The fetch byte is captured on the cycle it is on ram_dout, so
      // vram_dout stays stable even while CPU accesses use the port.
      if (vdp_rd_d1_q) begin
         hold_d = ram_dout;
      end

      case (state_q)
         ST_IDLE: begin
            if (cpu_wr_req || cpu_rd_req) begin
               addr_d  = cpu_addr;
               data_d  = cpu_wr_data;
               op_wr_d = cpu_wr_req;   // write wins a simultaneous request
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (vdp_dma_rd_tick) begin
               // The fetch owns the port this cycle. The counter saturates.
               if (stall_cnt_q != 8'hFF) begin
                  stall_cnt_d = stall_cnt_q + 8'd1;
               end
            end else begin
               stall_cnt_d = 8'd0;
               state_d     = op_wr_q ? ST_IDLE : ST_RDWAIT;
            end
         end
         ST_RDWAIT: begin
            cpu_rd_data_d  = ram_dout;
            cpu_rd_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pxclk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         op_wr_q        <= 1'b0;
         addr_q         <= '0;
         data_q         <= 8'd0;
         vdp_rd_d1_q    <= 1'b0;
         hold_q         <= 8'd0;
         cpu_rd_data_q  <= 8'd0;
         cpu_rd_valid_q <= 1'b0;
         stall_cnt_q    <= 8'd0;
      end else begin
         state_q        <= state_d;
         op_wr_q        <= op_wr_d;
         addr_q         <= addr_d;
         data_q         <= data_d;
         vdp_rd_d1_q    <= vdp_rd_d1_d;
         hold_q         <= hold_d;
         cpu_rd_data_q  <= cpu_rd_data_d;
         cpu_rd_valid_q <= cpu_rd_valid_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   // Port select. Gating ram_we with reset keeps a pending write from
   // landing in the cycle where reset is asserted.
   always_comb begin
      ram_addr = vdp_dma_rd_tick ? vdp_dma_addr : addr_q;
      ram_din  = data_q;
      ram_we   = (state_q == ST_PEND) && op_wr_q && !vdp_dma_rd_tick && !reset;
   end

   assign vram_dout    = vdp_rd_d1_q ? ram_dout : hold_q;
   assign cpu_busy     = (state_q != ST_IDLE);
   assign cpu_rd_data  = cpu_rd_data_q;
   assign cpu_rd_valid = cpu_rd_valid_q;

endmodule

// File: tb/tb_vdp_vram_arb.sv
// -----------------------------------------------------------------------------
// tb_vdp_vram_arb
//
// Self-checking bench for vdp_vram_arb. A behavioural VRAM is attached to the
// RAM port. A cycle-level reference model tracks the expected contents of
// memory, the buffered CPU request, the expected fetch byte and the queue of
// expected CPU read results. It is written from the arbitration rules, not
// from the RTL.
// -----------------------------------------------------------------------------
module tb_vdp_vram_arb;

   localparam int AW = 13;
   localparam int MEM_BYTES = 8192;

   // ---------------- clock / reset ----------------
   logic pxclk = 1'b0;
   logic reset = 1'b1;
   always #20 pxclk = ~pxclk;

   logic [AW-1:0] vdp_dma_addr = '0;
   logic          vdp_dma_rd_tick = 1'b0;
   logic [7:0]    vram_dout;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wr_data = '0;
   logic          cpu_wr_req = 1'b0;
   logic          cpu_rd_req = 1'b0;
   logic          cpu_busy;
   logic [7:0]    cpu_rd_data;
   logic          cpu_rd_valid;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic          ram_we;
   logic [7:0]    ram_dout;

   vdp_vram_arb #(.VRAM_SIZE(MEM_BYTES)) u_dut (
      .pxclk          (pxclk),
      .reset          (reset),
      .vdp_dma_addr   (vdp_dma_addr),
      .vdp_dma_rd_tick(vdp_dma_rd_tick),
      .vram_dout      (vram_dout),
      .cpu_addr       (cpu_addr),
      .cpu_wr_data    (cpu_wr_data),
      .cpu_wr_req     (cpu_wr_req),
      .cpu_rd_req     (cpu_rd_req),
      .cpu_busy       (cpu_busy),
      .cpu_rd_data    (cpu_rd_data),
      .cpu_rd_valid   (cpu_rd_valid),
      .ram_addr       (ram_addr),
      .ram_din        (ram_din),
      .ram_we         (ram_we),
      .ram_dout       (ram_dout)
   );

   // ---------------- behavioural VRAM ----------------
   function automatic logic [7:0] init_byte(input int i);
      if (i == 'h0123) return 8'h5A;
      if (i == 'h0040) return 8'h33;
      return 8'(i * 37 + 11);
   endfunction

   logic       mem_init = 1'b1;
   logic [7:0] ram_mem [0:MEM_BYTES-1];

   always @(posedge pxclk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_BYTES; i++) ram_mem[i] <= init_byte(i);
         ram_dout <= 8'd0;
      end else begin
         if (ram_we) ram_mem[ram_addr] <= ram_din;
         ram_dout <= ram_mem[ram_addr];
      end
   end

   // ---------------- scoreboard / reference model ----------------
   int checks = 0;
   int errors = 0;

   logic [7:0]    model_mem [0:MEM_BYTES-1];
   bit            m_pend, m_wr, m_rdwait, m_valid;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_data, m_rd_data, exp_vram;
   int            m_stall;
   logic [7:0]    exp_q[$];
   int            we_cnt, valid_cnt;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_wr = 0; m_rdwait = 0; m_valid = 0;
      m_addr = '0; m_data = 8'd0; m_rd_data = 8'd0; exp_vram = 8'd0;
      m_stall = 0;
      exp_q.delete();
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge. It drives one cycle of inputs, checks
   // the DUT against the model, advances the model across the rising edge and
   // returns at the next falling edge.
   task automatic step(input bit tk, input logic [AW-1:0] ta, input bit wr, input bit rd,
                       input logic [AW-1:0] ca, input logic [7:0] cd, input bit rst);
      bit         was_busy;
      bit         nv;
      logic [7:0] next_vram;
      reset           = rst;
      vdp_dma_rd_tick = tk;
      vdp_dma_addr    = ta;
      cpu_wr_req      = wr;
      cpu_rd_req      = rd;
      cpu_addr        = ca;
      cpu_wr_data     = cd;
      #1;
      was_busy = m_pend || m_rdwait;
      check_val("ram_we", ram_we, 32'(!rst && m_pend && m_wr && !tk));
      if (ram_we === 1'b1) we_cnt++;
      if (!rst) begin
         if (cpu_rd_valid === 1'b1) valid_cnt++;
         check_val("cpu_busy", cpu_busy, 32'(was_busy));
         check_val("vram_dout", vram_dout, exp_vram);
         check_val("cpu_rd_valid", cpu_rd_valid, 32'(m_valid));
         check_val("cpu_rd_data", cpu_rd_data, m_rd_data);
         check_val("ram_addr", ram_addr, tk ? ta : m_addr);
         check_val("ram_din", ram_din, m_data);
         check_val("stall_cnt", u_dut.stall_cnt_q, m_stall);
      end
      if (rst) begin
         model_reset();
      end else begin
         next_vram = tk ? model_mem[ta] : exp_vram;
         nv = 0;
         if (m_rdwait) begin
            nv = 1;
            m_rdwait = 0;
            if (exp_q.size() > 0) m_rd_data = exp_q.pop_front();
         end
         if (m_pend) begin
            if (tk) begin
               if (m_stall < 255) m_stall++;
            end else begin
               m_stall = 0;
               m_pend  = 0;
               if (m_wr) model_mem[m_addr] = m_data;
               else begin
                  exp_q.push_back(model_mem[m_addr]);
                  m_rdwait = 1;
               end
            end
         end
         if (!was_busy && (wr || rd)) begin
            m_pend = 1; m_wr = wr; m_addr = ca; m_data = cd;
         end
         m_valid  = nv;
         exp_vram = next_vram;
      end
      @(posedge pxclk);
      @(negedge pxclk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 8'd0, 0);
   endtask

   task automatic check_reset_values();
      check_val("rst_vram_dout", vram_dout, 0);
      check_val("rst_cpu_busy", cpu_busy, 0);
      check_val("rst_cpu_rd_data", cpu_rd_data, 0);
      check_val("rst_cpu_rd_valid", cpu_rd_valid, 0);
      check_val("rst_ram_we", ram_we, 0);
      check_val("rst_ram_addr", ram_addr, 0);
      check_val("rst_ram_din", ram_din, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ops;
      int cyc;
      bit tk, wr, rd;
      for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = init_byte(i);
      model_reset();
      we_cnt = 0;
      valid_cnt = 0;

      @(posedge pxclk);
      #1 mem_init = 1'b0;
      @(negedge pxclk);
      step(0, '0, 0, 0, '0, 8'd0, 1);
      step(0, '0, 0, 0, '0, 8'd0, 1);
      reset = 1'b0;
      #1;
      check_reset_values();

      // Idle fetch
      idle(2);
      step(1, 13'h0123, 0, 0, '0, 8'd0, 0);
      check_val("idle_fetch_t1", vram_dout, 8'h5A);
      idle(3);
      check_val("idle_fetch_hold", vram_dout, 8'h5A);

      // CPU write into a free slot, then a fetch of the same byte right after
      we_cnt = 0;
      step(0, '0, 1, 0, 13'h1FFF, 8'hA5, 0);
      step(0, '0, 0, 0, '0, 8'd0, 0);
      step(1, 13'h1FFF, 0, 0, '0, 8'd0, 0);
      check_val("wr_fetch_new", vram_dout, 8'hA5);
      idle(2);
      check_val("wr_we_count", we_cnt, 1);

      // Refill vram_dout with a known byte, then a CPU read that collides with a tick
      step(1, 13'h0123, 0, 0, '0, 8'd0, 0);
      idle(1);
      step(0, '0, 0, 1, 13'h0040, 8'd0, 0);
      step(1, 13'h0123, 0, 0, '0, 8'd0, 0);
      idle(2);
      check_val("coll_rd_valid", cpu_rd_valid, 1);
      check_val("coll_rd_data", cpu_rd_data, 8'h33);
      check_val("coll_vram_hold", vram_dout, 8'h5A);
      idle(2);

      // Simultaneous write and read: only the write happens
      valid_cnt = 0;
      we_cnt = 0;
      step(0, '0, 1, 1, 13'h0200, 8'h77, 0);
      idle(5);
      check_val("both_no_valid", valid_cnt, 0);
      check_val("both_one_write", we_cnt, 1);
      step(1, 13'h0200, 0, 0, '0, 8'd0, 0);
      check_val("both_written", vram_dout, 8'h77);
      idle(2);

      // Alternating ticks plus random CPU traffic
      ops = 0;
      cyc = 0;
      while (ops < 100 && cyc < 4000) begin
         tk = cyc[0];
         wr = 0;
         rd = 0;
         if ($urandom_range(0, 1) == 1) begin
            wr = ($urandom_range(0, 1) == 1);
            rd = !wr || ($urandom_range(0, 7) == 0);
            if (!(m_pend || m_rdwait)) ops++;
         end
         check_val("stress_stall_le1", 32'(u_dut.stall_cnt_q <= 8'd1), 1);
         step(tk, AW'($urandom_range(0, 15)), wr, rd, AW'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), 0);
         cyc++;
      end
      check_val("stress_ops_done", 32'(ops >= 100), 1);
      idle(4);

      // Reset while a write is pending
      step(0, '0, 1, 0, 13'h0005, 8'hEE, 0);
      step(0, '0, 0, 0, '0, 8'd0, 1);
      reset = 1'b0;
      #1;
      check_reset_values();
      idle(2);
      step(1, 13'h0005, 0, 0, '0, 8'd0, 0);
      check_val("rst_write_dropped", vram_dout, model_mem[5]);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vdp_vram_arb.md
# vdp_vram_arb

VRAM port arbiter for the VDP. It sits between a single-port synchronous VRAM (one-cycle read latency) and its two clients. The first client is the graphics fetch FSM, which drives `vdp_dma_addr`/`vdp_dma_rd_tick` and consumes `vram_dout`. The second is the CPU-side register interface, which issues single-byte read/write requests. VDP fetches always win; CPU accesses are buffered one deep and slipped into the next cycle without a VDP tick.

## Interface

- `VRAM_SIZE`, default 8*1024: VRAM bytes.
- `VRAM_ADDR_WIDTH`, default $clog2(VRAM_SIZE): address width (AW).

Ports:

- `pxclk`  in  1  25 MHz pixel clock
- `reset`  in  1  synchronous, active-high
- `vdp_dma_addr`  in  AW  fetch address from graphics FSM
- `vdp_dma_rd_tick`  in  1  1-cycle fetch strobe
- `vram_dout`  out  8  fetch data to graphics FSM
- `cpu_addr`  in  AW  CPU access address
- `cpu_wr_data`  in  8  CPU write byte
- `cpu_wr_req`  in  1  write request pulse
- `cpu_rd_req`  in  1  read request pulse
- `cpu_busy`  out  1  request buffer occupied
- `cpu_rd_data`  out  8  CPU read result
- `cpu_rd_valid`  out  1  1-cycle pulse, `cpu_rd_data` updated
- `ram_addr`  out  AW  VRAM address
- `ram_din`  out  8  VRAM write data
- `ram_we`  out  1  VRAM write enable
- `ram_dout`  in  8  VRAM read data, valid the cycle after address

## Operation

- Port select, combinational:
  - `vdp_dma_rd_tick`=1: `ram_addr`=`vdp_dma_addr`, `ram_we`=0.
  - Otherwise, in state PEND: `ram_addr`=latched CPU address; `ram_we`=1 if the latched op is a write.
  - Otherwise: `ram_addr`=latched CPU address, `ram_we`=0.
- `ram_we` is never 1 in a cycle with `vdp_dma_rd_tick`=1.
- `vdp_rd_d1` register = `vdp_dma_rd_tick` delayed 1 cycle.
- `vram_dout` = `vdp_rd_d1` ? `ram_dout` : `hold_reg`. `hold_reg` loads `ram_dout` whenever `vdp_rd_d1`=1. CPU traffic never disturbs `vram_dout`.
- CPU FSM states: IDLE, PEND, RDWAIT.
  - IDLE:
    - On `cpu_wr_req` or `cpu_rd_req`, latch `cpu_addr`, `cpu_wr_data` and op, then go to PEND.
    - If both requests are asserted together, the write wins and the read is dropped.
  - PEND:
    - If `vdp_dma_rd_tick`=1, stay (stall).
    - Else issue the access: a write goes to IDLE; a read goes to RDWAIT.
  - RDWAIT: load `cpu_rd_data` from `ram_dout`, pulse `cpu_rd_valid`, go to IDLE.
- `cpu_busy` = (state != IDLE), registered from state.
- Requests arriving while busy are ignored; the CPU interface must honour `cpu_busy`.
- `stall_cnt`: internal 8-bit saturating count of consecutive PEND stall cycles. It clears on issue. It is exposed only to the bench, via hierarchy.

## Timing

- Reset values: `vram_dout`=0 (`hold_reg`=0, `vdp_rd_d1`=0), `cpu_busy`=0, `cpu_rd_data`=0, `cpu_rd_valid`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, state=IDLE.
- Reset mid-operation discards any pending request. No write is issued after reset is sampled.
- VDP fetch latency:
  - Tick in cycle T: `vram_dout` is valid in T+1 (combinational from `ram_dout`).
  - `vram_dout` is held from T+2 until the cycle after the next tick.
  - This matches the FSM sampling `vram_dout` on the next odd-column cycle.
- CPU request sampled at edge E: state is PEND in cycle E+1. The access is issued in E+1 if there is no tick, else in E+2. Ticks never occur on consecutive cycles, so the worst case is 1 stall cycle.
- Write: `cpu_busy` is high for 1–2 cycles.
- Read: `cpu_rd_valid` pulses one cycle after the data is captured. Total latency from request to valid is 3–4 cycles.
- A CPU write issued in cycle T followed by a VDP tick in T+1 to the same address returns the new byte.
- A VDP tick and a CPU read of the same address in adjacent cycles are each served from their own cycle's `ram_dout`.

## Test plan

- **Idle fetch:** with no CPU traffic, tick with addr 0x0123 (RAM preloaded 0x5A) → `vram_dout`=0x5A in the next cycle and held until the next tick.
- **CPU write, free slot:** `cpu_wr_req` addr 0x1FFF, data 0xA5, no ticks → `ram_we`=1 exactly 1 cycle with `ram_addr`=0x1FFF; `cpu_busy` is high 1 cycle; a later VDP fetch of 0x1FFF returns 0xA5.
- **CPU read collides with tick:** `cpu_rd_req` addr 0x0040 (0x33) with a tick landing on the PEND cycle → 1 stall cycle, `cpu_rd_valid` 4 cycles after the request, `cpu_rd_data`=0x33. `vram_dout` holds the VDP byte throughout.
- **Alternating tick stress:** ticks every other cycle plus 100 random CPU writes/reads → `ram_we` never coincides with a tick, `stall_cnt` never exceeds 1, and all reads match the model.
- **Simultaneous `wr_req`+`rd_req`:** → only the write is performed and `cpu_rd_valid` never pulses.
- **Reset mid-operation:** assert reset while in PEND with a write → no `ram_we`, and all outputs return to their reset values the next cycle.
